score_argmax: RTL and testbench

SCORE_ARGMAX -- requirements
Module: score_argmax

---
 rtl/score_argmax.sv | 126 ++++++++++++
 tb/tb_score_argmax.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_argmax.sv
// score_argmax: collects NUM_CLASSES unsigned scores per frame and reports the
// index and value of the largest one (lowest index wins ties).
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   start                 one-cycle pulse; begins (or restarts) a frame
//   in_valid/in_ready     score handshake; class index is the arrival order
//   in_score              incoming score
//   out_valid/out_ready   result handshake; result held until accepted
//   out_class, out_score  winning index and score, zero while out_valid=0
//   busy                  high whenever a frame is in flight or unacknowledged
//   rd_idx, rd_score      combinational read port into the score buffer
module score_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SCORE_W-1:0] in_score,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_class,
    output logic [SCORE_W-1:0] out_score,
    output logic               busy,
    input  logic [3:0]         rd_idx,
    output logic [SCORE_W-1:0] rd_score
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [3:0]         max_idx;
    logic [SCORE_W-1:0] max_score;
    logic [SCORE_W-1:0] buffer [NUM_CLASSES];

    logic               take;
    logic               last;
    logic               upd;
    logic [SCORE_W-1:0] nxt_score;
    logic [3:0]         nxt_idx;

    // start in COLLECT aborts the frame, so a score offered alongside it is dropped
    assign take      = (state == COLLECT) && in_valid && !start;
    assign last      = cnt == 4'(NUM_CLASSES - 1);
    // strict compare keeps the earliest index on ties
    assign upd       = (cnt == 4'd0) || (in_score > max_score);
    assign nxt_score = upd ? in_score : max_score;
    assign nxt_idx   = upd ? cnt : max_idx;
    assign rd_score  = (32'(rd_idx) < NUM_CLASSES) ? buffer[rd_idx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) buffer[i] <= '0;
        end else if (take) begin
            buffer[cnt] <= in_score;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            max_idx   <= '0;
            max_score <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_score <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= COLLECT;
                        cnt       <= '0;
                        max_idx   <= '0;
                        max_score <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        cnt       <= '0;
                        max_idx   <= '0;
                        max_score <= '0;
                    end else if (in_valid) begin
                        max_idx   <= nxt_idx;
                        max_score <= nxt_score;
                        // the counter parks on the last index instead of wrapping
                        if (last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_class <= nxt_idx;
                            out_score <= nxt_score;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_class <= '0;
                        out_score <= '0;
                        if (start) begin
                            state     <= COLLECT;
                            cnt       <= '0;
                            max_idx   <= '0;
                            max_score <= '0;
                            in_ready  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_argmax.sv
// tb_score_argmax: table-driven and directed checks of score_argmax.
module tb_score_argmax;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_score = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_class;
    logic [7:0] out_score;
    logic       busy;
    logic [3:0] rd_idx = '0;
    logic [7:0] rd_score;

    int total = 0;
    int bad = 0;

    typedef logic [0:9][7:0] frame_t;
    typedef struct packed {
        frame_t     s;
        logic [3:0] cls;
        logic [7:0] sc;
    } vec_t;

    vec_t vecs [6];

    score_argmax #(.NUM_CLASSES(10), .SCORE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_score(in_score), .out_valid(out_valid),
        .out_ready(out_ready), .out_class(out_class), .out_score(out_score),
        .busy(busy), .rd_idx(rd_idx), .rd_score(rd_score)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_ready", in_ready, 1);
        chk("start_busy", busy, 1);
    endtask

    task automatic feed(input frame_t s, input bit gap);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_score = s[i];
            if (i == 9) chk("pre_last_out_valid", out_valid, 0);
            tick();
            if (gap && i < 9) begin
                in_valid = 1'b0;
                in_score = 8'hEE;
                tick();
            end
        end
        in_valid = 1'b0;
        in_score = '0;
        chk("latency_out_valid", out_valid, 1);
        chk("done_in_ready", in_ready, 0);
    endtask

    task automatic check_buf(input frame_t s);
        for (int i = 0; i < 10; i++) begin
            rd_idx = 4'(i);
            #1;
            chk($sformatf("rd_score[%0d]", i), rd_score, s[i]);
        end
        rd_idx = 4'd12;
        #1;
        chk("rd_score_oob", rd_score, 0);
    endtask

    task automatic finish_frame;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_out_class", out_class, 0);
        chk("idle_out_score", out_score, 0);
        chk("idle_in_ready", in_ready, 0);
    endtask

    initial begin
        frame_t t;
        vecs[0].s = {8'd10, 8'd20, 8'd200, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        vecs[0].cls = 4'd2; vecs[0].sc = 8'd200;
        vecs[1].s = {8'd5, 8'd250, 8'd7, 8'd250, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[1].cls = 4'd1; vecs[1].sc = 8'd250;
        vecs[2].s = '0;
        vecs[2].cls = 4'd0; vecs[2].sc = 8'd0;
        vecs[3].s = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd255};
        vecs[3].cls = 4'd9; vecs[3].sc = 8'd255;
        vecs[4].s = {10{8'd255}};
        vecs[4].cls = 4'd0; vecs[4].sc = 8'd255;
        vecs[5].s = {8'd128, 8'd127, 8'd129, 8'd129, 8'd3, 8'd200, 8'd199, 8'd200, 8'd0, 8'd1};
        vecs[5].cls = 4'd5; vecs[5].sc = 8'd200;

        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_score", out_score, 0);
        chk("rst_rd_score", rd_score, 0);
        rst = 1'b0;

        // first start lands on the first edge after reset release
        for (int k = 0; k < 6; k++) begin
            start_frame();
            feed(vecs[k].s, 1'b0);
            chk($sformatf("v%0d_class", k), out_class, vecs[k].cls);
            chk($sformatf("v%0d_score", k), out_score, vecs[k].sc);
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("done_start_ignored_valid", out_valid, 1);
            chk("done_start_ignored_ready", in_ready, 0);
            check_buf(vecs[k].s);
            finish_frame();
        end

        // backpressure: gapped input, then a held result
        start_frame();
        feed(vecs[5].s, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_class", out_class, 5);
            chk("bp_out_score", out_score, 200);
        end
        finish_frame();

        // abort: restart after 4 scores with a score offered in the same cycle
        start_frame();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_score = 8'(100 + i);
            tick();
        end
        start = 1'b1;
        in_score = 8'd250;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 10; i++) t[i] = 8'(i + 1);
        feed(t, 1'b0);
        chk("abort_class", out_class, 9);
        chk("abort_score", out_score, 10);
        check_buf(t);
        finish_frame();

        // asynchronous reset in the middle of a frame
        start_frame();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_score = 8'(50 + i);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_in_ready", in_ready, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            chk($sformatf("rst_rd_score[%0d]", i), rd_score, 0);
        end
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_score = 8'd77;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_rst_out_valid", out_valid, 0);
            chk("post_rst_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;

        // back-to-back: accept result and restart in one cycle
        start_frame();
        feed(vecs[0].s, 1'b0);
        chk("b2b_first_class", out_class, 2);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        chk("b2b_in_ready", in_ready, 1);
        chk("b2b_out_valid", out_valid, 0);
        chk("b2b_out_class", out_class, 0);
        chk("b2b_busy", busy, 1);
        feed('0, 1'b0);
        chk("b2b_zero_class", out_class, 0);
        chk("b2b_zero_score", out_score, 0);
        finish_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
